// File: rtl/bolt_scheduler_pkg.sv
// Shared types and defaults for the bolt scheduler: slot lifecycle states, screen coordinates
// and the off-screen test used by the per-slot retire logic.
package bolt_scheduler_pkg;

    localparam int unsigned COORD_W      = 11;
    localparam int unsigned DEF_Y_TOP    = 8;
    localparam int unsigned DEF_Y_BOTTOM = 470;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        FLY,
        RETIRE
    } slot_state_t;

    // Upward bolts leave through the top edge, downward bolts through the bottom edge.
    function automatic logic past_limit(input coord_t y, input logic up,
                                        input coord_t top, input coord_t bottom);
        return up ? (y <= top) : (y >= bottom);
    endfunction

endpackage

// File: rtl/bolt_scheduler_rr_arbiter.sv
// Round-robin arbiter over the invader column requests: combinational one-hot grant starting
// from the pointer, pointer advances past the winner whenever a grant is issued.
module bolt_scheduler_rr_arbiter #(
    parameter int unsigned  NUM_REQ = 8,
    localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_grant_en,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_valid
);

    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_cand;
    logic             w_found;

    always_comb begin
        w_found = 1'b0;
        w_cand  = '0;
        o_idx   = '0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            w_cand = IDX_W'((int'(r_ptr) + k) % int'(NUM_REQ));
            if (!w_found && i_req[w_cand]) begin
                w_found = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

    assign o_valid = i_grant_en & w_found;
    assign o_grant = o_valid ? (NUM_REQ'(1) << o_idx) : '0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr <= '0;
        end else if (o_valid) begin
            r_ptr <= (o_idx == IDX_W'(NUM_REQ - 1)) ? '0 : o_idx + 1'b1;
        end
    end

endmodule

// File: rtl/bolt_scheduler.sv
// Bolt mover pool owner: grants player/invader fire to free slots, latches launch points,
// drives each mover's shoot command and retires bolts on hit, off-screen or game stop.
module bolt_scheduler
    import bolt_scheduler_pkg::*;
#(
    parameter int unsigned P_SLOTS  = 1,
    parameter int unsigned I_SLOTS  = 3,
    parameter int unsigned NUM_COLS = 8,
    parameter int unsigned Y_TOP    = DEF_Y_TOP,
    parameter int unsigned Y_BOTTOM = DEF_Y_BOTTOM,
    parameter int unsigned FIRE_GAP = 20
) (
    input  logic                             i_clk,
    input  logic                             i_resetN,
    input  logic                             i_startOfFrame,
    input  logic                             i_gameActive,
    input  logic                             i_playerFire,
    input  coord_t                           i_playerX,
    input  coord_t                           i_playerY,
    input  logic   [NUM_COLS-1:0]            i_colReq,
    input  coord_t [NUM_COLS-1:0]            i_colX,
    input  coord_t [NUM_COLS-1:0]            i_colY,
    input  coord_t [P_SLOTS+I_SLOTS-1:0]     i_boltY,
    input  logic   [P_SLOTS+I_SLOTS-1:0]     i_boltHit,
    output logic   [P_SLOTS+I_SLOTS-1:0]     o_shootCmd,
    output coord_t [P_SLOTS+I_SLOTS-1:0]     o_launchX,
    output coord_t [P_SLOTS+I_SLOTS-1:0]     o_launchY,
    output logic   [NUM_COLS-1:0]            o_colGrant
);

    localparam int unsigned N     = P_SLOTS + I_SLOTS;
    localparam int unsigned COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int unsigned GAP_W = 16;

    logic               r_fire_prev;
    logic [GAP_W-1:0]   r_gap;
    logic [NUM_COLS-1:0] r_colGrant;

    logic               w_player_go;
    logic               w_inv_free;
    logic               w_arb_en;
    logic               w_inv_go;
    logic [NUM_COLS-1:0] w_arb_grant;
    logic [COL_W-1:0]   w_arb_idx;
    logic [N-1:0]       w_idle;
    logic [N-1:0]       w_slot_grant;
    logic               w_p_taken;
    logic               w_i_taken;

    // Edge-detect so a held button launches only one bolt.
    assign w_player_go = i_gameActive & i_playerFire & ~r_fire_prev;
    assign w_inv_free  = |w_idle[N-1:P_SLOTS];
    assign w_arb_en    = i_gameActive & ~i_resetN & (r_gap == '0) & w_inv_free;

    bolt_scheduler_rr_arbiter #(
        .NUM_REQ (NUM_COLS)
    ) u_col_arb (
        .i_clk      (i_clk),
        .i_rst      (i_resetN),
        .i_req      (i_colReq),
        .i_grant_en (w_arb_en),
        .o_grant    (w_arb_grant),
        .o_idx      (w_arb_idx),
        .o_valid    (w_inv_go)
    );

    always_comb begin
        w_slot_grant = '0;
        w_p_taken    = 1'b0;
        w_i_taken    = 1'b0;
        for (int s = 0; s < int'(P_SLOTS); s++) begin
            if (w_player_go && w_idle[s] && !w_p_taken) begin
                w_slot_grant[s] = 1'b1;
                w_p_taken       = 1'b1;
            end
        end
        for (int s = int'(P_SLOTS); s < int'(N); s++) begin
            if (w_inv_go && w_idle[s] && !w_i_taken) begin
                w_slot_grant[s] = 1'b1;
                w_i_taken       = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_resetN) begin
            r_fire_prev <= 1'b0;
            r_gap       <= '0;
            r_colGrant  <= '0;
        end else begin
            r_fire_prev <= i_playerFire;
            r_colGrant  <= w_arb_grant;
            if (w_inv_go) begin
                r_gap <= GAP_W'(FIRE_GAP);
            end else if (i_startOfFrame && (r_gap != '0)) begin
                r_gap <= r_gap - 1'b1;
            end
        end
    end

    assign o_colGrant = r_colGrant;

    for (genvar g = 0; g < int'(N); g++) begin : g_slot
        localparam bit UP = (g < int'(P_SLOTS));

        slot_state_t r_state;
        logic        r_shoot;
        logic        r_moved;
        coord_t      r_lx;
        coord_t      r_ly;
        coord_t      w_lx_in;
        coord_t      w_ly_in;
        logic        w_past;
        logic        w_retire;

        assign w_lx_in  = UP ? i_playerX : i_colX[w_arb_idx];
        assign w_ly_in  = UP ? i_playerY : i_colY[w_arb_idx];
        assign w_past   = past_limit(i_boltY[g], UP, COORD_W'(Y_TOP), COORD_W'(Y_BOTTOM));
        // The mover reports a meaningless y until it has moved once, so gate on r_moved.
        assign w_retire = ~i_gameActive | i_boltHit[g] | (r_moved & w_past);

        always_ff @(posedge i_clk) begin
            if (i_resetN) begin
                r_state <= IDLE;
                r_shoot <= 1'b0;
                r_moved <= 1'b0;
                r_lx    <= '0;
                r_ly    <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_slot_grant[g]) begin
                            r_state <= ARM;
                            r_lx    <= w_lx_in;
                            r_ly    <= w_ly_in;
                            r_moved <= 1'b0;
                        end
                    end
                    ARM: begin
                        if (!i_gameActive) begin
                            r_state <= RETIRE;
                        end else begin
                            r_state <= FLY;
                            r_shoot <= 1'b1;
                        end
                    end
                    FLY: begin
                        if (w_retire) begin
                            r_state <= RETIRE;
                            r_shoot <= 1'b0;
                        end else if (i_startOfFrame) begin
                            r_moved <= 1'b1;
                        end
                    end
                    RETIRE: r_state <= IDLE;
                    default: begin
                        r_state <= IDLE;
                        r_shoot <= 1'b0;
                    end
                endcase
            end
        end

        assign w_idle[g]     = (r_state == IDLE);
        assign o_shootCmd[g] = r_shoot;
        assign o_launchX[g]  = r_lx;
        assign o_launchY[g]  = r_ly;
    end

endmodule

// File: tb/tb_bolt_scheduler.sv
// Randomized scoreboard bench for bolt_scheduler: a timestamp-based slot model predicts launches,
// retirements and column grants; a monitor matches them against shoot edges and grant pulses.
module tb_bolt_scheduler;
    import bolt_scheduler_pkg::*;

    localparam int P    = 1;
    localparam int I    = 3;
    localparam int N    = P + I;
    localparam int C    = 8;
    localparam int YT   = 8;
    localparam int YB   = 470;
    localparam int GAP  = 2;
    localparam int NCYC = 3000;
    localparam int INF  = 1 << 30;
    localparam int STEP = 40;

    logic clk = 1'b1;
    logic rst, sof, act, fire;
    coord_t px, py;
    logic   [C-1:0] creq;
    coord_t [C-1:0] cx, cy;
    coord_t [N-1:0] by;
    logic   [N-1:0] hit;
    logic   [N-1:0] shoot;
    coord_t [N-1:0] lx, ly;
    logic   [C-1:0] cgrant;

    always #5 clk = ~clk;

    bolt_scheduler #(
        .P_SLOTS  (P),
        .I_SLOTS  (I),
        .NUM_COLS (C),
        .Y_TOP    (YT),
        .Y_BOTTOM (YB),
        .FIRE_GAP (GAP)
    ) dut (
        .i_clk          (clk),
        .i_resetN       (rst),
        .i_startOfFrame (sof),
        .i_gameActive   (act),
        .i_playerFire   (fire),
        .i_playerX      (px),
        .i_playerY      (py),
        .i_colReq       (creq),
        .i_colX         (cx),
        .i_colY         (cy),
        .i_boltY        (by),
        .i_boltHit      (hit),
        .o_shootCmd     (shoot),
        .o_launchX      (lx),
        .o_launchY      (ly),
        .o_colGrant     (cgrant)
    );

    typedef struct { int cyc; int slot; int x; int y; } launch_ev_t;
    typedef struct { int cyc; int slot; } fall_ev_t;
    typedef struct { int cyc; int col; } grant_ev_t;

    launch_ev_t q_launch[$];
    fall_ev_t   q_fall[$];
    grant_ev_t  q_grant[$];

    int vectors = 0;
    int miscompares = 0;
    int cur_p = 0;
    bit done = 0;
    int inact = 0;

    // Model: each slot is described by the posedge it was granted and the posedge it retired.
    bit m_used[N];
    int m_launch[N];
    int m_end[N];
    int m_x[N];
    int m_y[N];
    bit m_moved[N];
    int m_ypos[N];
    int m_gap;
    int m_ptr;
    bit m_fire_prev;

    task automatic check(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic bit m_fly(input int s, input int p);
        return m_used[s] && (p >= m_launch[s] + 1) && (p < m_end[s]);
    endfunction

    function automatic bit m_arm(input int s, input int p);
        return m_used[s] && (p == m_launch[s]);
    endfunction

    function automatic bit m_free(input int s, input int p);
        return !m_used[s] || (p > m_end[s]);
    endfunction

    task automatic m_start(input int s, input int p, input int x, input int y);
        m_used[s]   = 1;
        m_launch[s] = p;
        m_end[s]    = INF;
        m_x[s]      = x;
        m_y[s]      = y;
        m_moved[s]  = 0;
        m_ypos[s]   = y;
    endtask

    task automatic model_step(input int p);
        bit beyond;
        bit rise;
        int col;
        int slot;
        if (rst) begin
            for (int s = 0; s < N; s++) begin
                if (m_fly(s, p - 1)) q_fall.push_back('{p, s});
                m_used[s]  = 0;
                m_moved[s] = 0;
            end
            m_gap = 0;
            m_ptr = 0;
            m_fire_prev = 0;
            return;
        end
        for (int s = 0; s < N; s++) begin
            if (m_fly(s, p - 1)) begin
                beyond = (s < P) ? (int'(by[s]) <= YT) : (int'(by[s]) >= YB);
                if (!act || hit[s] || (m_moved[s] && beyond)) begin
                    m_end[s] = p;
                    q_fall.push_back('{p, s});
                end else if (sof) begin
                    m_moved[s] = 1;
                    if (s < P) m_ypos[s] = (m_ypos[s] > STEP) ? m_ypos[s] - STEP : 0;
                    else       m_ypos[s] = (m_ypos[s] + STEP > 2047) ? 2047 : m_ypos[s] + STEP;
                end
            end else if (m_arm(s, p - 1)) begin
                if (!act) m_end[s] = p;
                else      q_launch.push_back('{p, s, m_x[s], m_y[s]});
            end
        end
        rise = fire && !m_fire_prev;
        m_fire_prev = fire;
        if (act && rise) begin
            slot = -1;
            for (int s = 0; s < P; s++) if (slot < 0 && m_free(s, p - 1)) slot = s;
            if (slot >= 0) m_start(slot, p, int'(px), int'(py));
        end
        slot = -1;
        for (int s = P; s < N; s++) if (slot < 0 && m_free(s, p - 1)) slot = s;
        if (act && m_gap == 0 && slot >= 0 && creq != '0) begin
            col = -1;
            for (int k = 0; k < C; k++) if (col < 0 && creq[(m_ptr + k) % C]) col = (m_ptr + k) % C;
            m_ptr = (col + 1) % C;
            m_start(slot, p, int'(cx[col]), int'(cy[col]));
            q_grant.push_back('{p, col});
            m_gap = GAP;
        end else if (sof && m_gap > 0) begin
            m_gap--;
        end
    endtask

    task automatic drive(input int p);
        rst = (p <= 3) || (p >= 1500 && p <= 1501);
        sof = (p % 6 == 0);
        if (inact > 0) begin
            act = 0;
            inact--;
        end else begin
            act = 1;
            if ($urandom_range(0, 299) == 0) inact = int'($urandom_range(5, 15));
        end
        if ($urandom_range(0, 11) == 0) fire = ~fire;
        if ($urandom_range(0, 19) == 0)
            creq = ($urandom_range(0, 3) == 0) ? '0 : 8'($urandom & $urandom);
        px = 11'($urandom);
        py = 11'($urandom_range(300, 460));
        for (int c = 0; c < C; c++) begin
            cx[c] = 11'($urandom);
            cy[c] = 11'($urandom_range(20, 200));
        end
        for (int s = 0; s < N; s++) begin
            hit[s] = ($urandom_range(0, 79) == 0);
            by[s]  = (m_fly(s, p - 1) && m_moved[s]) ? 11'(m_ypos[s]) : 11'($urandom);
        end
    endtask

    initial begin
        rst = 1; sof = 0; act = 0; fire = 0; px = '0; py = '0;
        creq = '0; cx = '0; cy = '0; by = '0; hit = '0;
        for (int s = 0; s < N; s++) begin
            m_used[s] = 0;
            m_moved[s] = 0;
        end
        m_gap = 0; m_ptr = 0; m_fire_prev = 0;
        for (int p = 1; p <= NCYC; p++) begin
            @(negedge clk);
            drive(p);
            model_step(p);
            cur_p = p;
            @(posedge clk);
            #1;
            if (p == 3) begin
                check("reset shootCmd", int'(shoot), 0);
                check("reset launchX", int'(lx), 0);
                check("reset launchY", int'(ly), 0);
                check("reset colGrant", int'(cgrant), 0);
            end
        end
        #2;
        done = 1;
        check("pending launches", q_launch.size(), 0);
        check("pending retires", q_fall.size(), 0);
        check("pending grants", q_grant.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    logic [N-1:0] prev_shoot = '0;

    always @(posedge clk) begin
        launch_ev_t le;
        fall_ev_t   fe;
        grant_ev_t  ge;
        #1;
        if (cur_p > 0 && !done) begin
            for (int s = 0; s < N; s++) begin
                if (shoot[s] && !prev_shoot[s]) begin
                    if (q_launch.size() == 0) begin
                        check("unexpected launch slot", s, -1);
                    end else begin
                        le = q_launch.pop_front();
                        check("launch cycle", cur_p, le.cyc);
                        check("launch slot", s, le.slot);
                        check("launchX", int'(lx[s]), le.x);
                        check("launchY", int'(ly[s]), le.y);
                    end
                end
                if (!shoot[s] && prev_shoot[s]) begin
                    if (q_fall.size() == 0) begin
                        check("unexpected retire slot", s, -1);
                    end else begin
                        fe = q_fall.pop_front();
                        check("retire cycle", cur_p, fe.cyc);
                        check("retire slot", s, fe.slot);
                    end
                end
            end
            if (cgrant != '0) begin
                if (q_grant.size() == 0) begin
                    check("unexpected colGrant", int'(cgrant), 0);
                end else begin
                    ge = q_grant.pop_front();
                    check("grant cycle", cur_p, ge.cyc);
                    check("colGrant", int'(cgrant), 1 << ge.col);
                end
            end
            prev_shoot = shoot;
        end
    end

endmodule
